rnm_dir_arbiter: RTL and testbench
==================================

RNM_DIR_ARBITER -- requirements
Module: rnm_dir_arbiter

Interface
REQ-001 SHALL provide parameter TURN_CYC, default 2: number of turnaround cycles (both drivers off) after every release, legal range 1..255.
REQ-002 SHALL provide parameter MAX_HOLD, default 16: maximum owned cycles before a forced release, legal range 1..65535; used only when RNM_DIR_ARB_TIMEOUT_EN is defined.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide port l_req  input  1  logic-side request to drive the shared L/R connection (level).
REQ-006 SHALL provide port r_req  input  1  real-side request to drive the shared connection (level).
REQ-007 SHALL provide port l_done  input  1  logic-side release pulse.
REQ-008 SHALL provide port r_done  input  1  real-side release pulse.
REQ-009 SHALL provide port l_gnt  output  1  logic side owns the connection; it enables the L-to-R driver.
REQ-010 SHALL provide port r_gnt  output  1  real side owns the connection; it enables the R-to-L driver.
REQ-011 SHALL provide port turn  output  1  turnaround active; both drivers off.
REQ-012 SHALL provide port timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, OWN_L, OWN_R and TURN.
REQ-014 SHALL make l_gnt, r_gnt and turn direct state decodes, mutually exclusive in every cycle.
REQ-015 IDLE: if only l_req is high, SHALL go to OWN_L at the next edge; if only r_req is high, SHALL go to OWN_R; if neither is high, SHALL stay in IDLE.
REQ-016 IDLE with l_req and r_req both high SHALL grant the side that did not own last (round-robin pointer last_own).
REQ-017 Request-to-grant latency from IDLE SHALL be exactly 1 cycle.
REQ-018 In OWN_x, the owner's done pulse or the owner's req going low SHALL cause a move to TURN at the next edge and SHALL set last_own to x.
REQ-019 done pulses from the non-owner, or received in IDLE or TURN, SHALL be ignored.
REQ-020 TURN SHALL last exactly TURN_CYC cycles, counted by an 8-bit down-counter loaded on entry, then SHALL go to IDLE.
REQ-021 Requests are not sampled during TURN, so the earliest re-grant is TURN_CYC+1 cycles after leaving OWN_x.
REQ-022 Requests that stay high through TURN SHALL be arbitrated normally in IDLE; no request is latched or queued.
REQ-023 In the same cycle, done together with a req drop SHALL be treated as a single release.

Reset
REQ-024 While rst is high: state=IDLE, last_own=R (logic side wins the first tie), counters=0, and l_gnt=r_gnt=turn=timeout=0 asynchronously.
REQ-025 Reset asserted mid-ownership SHALL drop the grant immediately with no turnaround; after release, arbitration restarts from IDLE.

Configuration
REQ-026 With RNM_DIR_ARB_TIMEOUT_EN defined, a 16-bit hold counter SHALL be cleared on entry to OWN_x and increment each owned cycle.
REQ-027 When the hold counter reaches MAX_HOLD, the block SHALL force a move to TURN (same rules as a normal release, last_own=x) and pulse timeout for 1 cycle.
REQ-028 If done arrives on the same cycle the hold counter reaches MAX_HOLD, the block SHALL perform a normal release and SHALL NOT pulse timeout.
REQ-029 Without RNM_DIR_ARB_TIMEOUT_EN, no hold counter SHALL exist, ownership SHALL be unlimited, and timeout SHALL be tied to 0.

Verification
REQ-030 Reset, then l_req=1 at cycle 0 -> l_gnt=1 from cycle 1; l_done at cycle 5 -> turn=1 for cycles 6-7, IDLE at cycle 8 (TURN_CYC=2).
REQ-031 l_req=r_req=1 held continuously after reset -> grant sequence L, turn x2, R, turn x2, L, with each owner releasing via done after 3 cycles.
REQ-032 r_done pulsed while in OWN_L, and l_done pulsed during TURN -> no state change.
REQ-033 rst asserted asynchronously mid-cycle while in OWN_R -> r_gnt=0 before the next clk edge; after release, l_req=r_req=1 -> L granted.
REQ-034 With the macro defined (MAX_HOLD=4) and l_req held, no done -> l_gnt for 4 cycles, timeout=1 for 1 cycle, then TURN; done on cycle 4 -> timeout stays 0.
REQ-035 Without the macro, l_req held for 1000 cycles -> l_gnt stays 1 and timeout stays 0 throughout.

Source files
------------

// File: rtl/rnm_dir_arbiter_if.sv
// rtl/rnm_dir_arbiter_if.sv - request/release/grant bundle for the L/R direction arbiter
interface rnm_dir_arbiter_if;
    logic l_req;
    logic r_req;
    logic l_done;
    logic r_done;
    logic l_gnt;
    logic r_gnt;
    logic turn;
    logic timeout;

    modport master (
        output l_req, r_req, l_done, r_done,
        input  l_gnt, r_gnt, turn, timeout
    );

    modport slave (
        input  l_req, r_req, l_done, r_done,
        output l_gnt, r_gnt, turn, timeout
    );
endinterface

// File: rtl/rnm_dir_arbiter.sv
// rtl/rnm_dir_arbiter.sv - round-robin direction arbiter with turnaround for a shared L/R connection
// Optional ownership timeout enabled by macro RNM_DIR_ARB_TIMEOUT_EN.
module rnm_dir_arbiter #(
    parameter int TURN_CYC = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    rnm_dir_arbiter_if.slave   bus
);
    if (TURN_CYC < 1 || TURN_CYC > 255) begin : g_bad_turn
        $error("TURN_CYC out of range 1..255");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_hold
        $error("MAX_HOLD out of range 1..65535");
    end

    typedef enum logic [1:0] {IDLE, OWN_L, OWN_R, TURN} state_t;

    // TURN is held for TURN_CYC cycles: counter starts at TURN_CYC-1 and exits at 0
    localparam logic [7:0] TURN_LOAD = 8'(TURN_CYC - 1);

    state_t     state;
    logic       last_own;       // 1: real side owned last
    logic [7:0] turn_cnt;
    logic       l_rel;
    logic       r_rel;
    logic       l_end;
    logic       r_end;

    assign l_rel = bus.l_done || !bus.l_req;
    assign r_rel = bus.r_done || !bus.r_req;

`ifdef RNM_DIR_ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

    logic [15:0] hold_cnt;
    logic        hold_hit;
    logic        timeout_q;

    // hold_cnt counts completed owned cycles, so the MAX_HOLD-th owned cycle sees HOLD_LAST
    assign hold_hit    = (hold_cnt == HOLD_LAST);
    assign l_end       = l_rel || hold_hit;
    assign r_end       = r_rel || hold_hit;
    assign bus.timeout = timeout_q;
`else
    assign l_end       = l_rel;
    assign r_end       = r_rel;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_own  <= 1'b1;
            turn_cnt  <= 8'd0;
`ifdef RNM_DIR_ARB_TIMEOUT_EN
            hold_cnt  <= 16'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef RNM_DIR_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef RNM_DIR_ARB_TIMEOUT_EN
                    hold_cnt <= 16'd0;
`endif
                    if (bus.l_req && (!bus.r_req || last_own)) begin
                        state <= OWN_L;
                    end else if (bus.r_req) begin
                        state <= OWN_R;
                    end
                end
                OWN_L: begin
                    if (l_end) begin
                        state    <= TURN;
                        last_own <= 1'b0;
                        turn_cnt <= TURN_LOAD;
`ifdef RNM_DIR_ARB_TIMEOUT_EN
                        timeout_q <= !l_rel;
`endif
                    end
`ifdef RNM_DIR_ARB_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
`endif
                end
                OWN_R: begin
                    if (r_end) begin
                        state    <= TURN;
                        last_own <= 1'b1;
                        turn_cnt <= TURN_LOAD;
`ifdef RNM_DIR_ARB_TIMEOUT_EN
                        timeout_q <= !r_rel;
`endif
                    end
`ifdef RNM_DIR_ARB_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
`endif
                end
                TURN: begin
                    if (turn_cnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded straight from state so async reset removes the grant at once
    assign bus.l_gnt = (state == OWN_L);
    assign bus.r_gnt = (state == OWN_R);
    assign bus.turn  = (state == TURN);
endmodule

// File: tb/tb_rnm_dir_arbiter.sv
// tb/tb_rnm_dir_arbiter.sv - directed scoreboard bench for rnm_dir_arbiter
module tb_rnm_dir_arbiter;
    logic clk;
    logic rst;
    rnm_dir_arbiter_if bus();

    rnm_dir_arbiter #(.TURN_CYC(2), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {l_gnt, r_gnt, turn, timeout}
    localparam logic [3:0] EI  = 4'b0000;
    localparam logic [3:0] EL  = 4'b1000;
    localparam logic [3:0] ER  = 4'b0100;
    localparam logic [3:0] ET  = 4'b0010;
    localparam logic [3:0] ETO = 4'b0011;

    logic [3:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag);
        logic [3:0] obs;
        logic [3:0] ev;
        obs = {bus.l_gnt, bus.r_gnt, bus.turn, bus.timeout};
        ev  = exp_q.pop_front();
        vectors++;
        assert (obs === ev) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, ev);
        end
    endtask

    task automatic expect_now(input logic [3:0] e, input string tag);
        exp_q.push_back(e);
        check(tag);
    endtask

    // Inputs for this cycle; expected outputs for the next cycle
    task automatic step(input logic lr, input logic rr, input logic ld, input logic rd,
                        input logic [3:0] e, input string tag);
        bus.l_req  = lr;
        bus.r_req  = rr;
        bus.l_done = ld;
        bus.r_done = rd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic do_reset(input string tag);
        bus.l_req  = 1'b0;
        bus.r_req  = 1'b0;
        bus.l_done = 1'b0;
        bus.r_done = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_now(EI, tag);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bus.l_req  = 1'b0;
        bus.r_req  = 1'b0;
        bus.l_done = 1'b0;
        bus.r_done = 1'b0;
        #1;
        expect_now(EI, "reset_async");
        do_reset("reset_state");

        // single L request, done at cycle 5, stray r_done in OWN_L, l_done in TURN
        step(1, 0, 0, 0, EL, "t1_c1_grant");
        step(1, 0, 0, 0, EL, "t1_c2");
        step(1, 0, 0, 1, EL, "t1_c3_rdone_ignored");
        step(1, 0, 0, 0, EL, "t1_c4");
        step(1, 0, 0, 0, EL, "t1_c5");
        step(1, 0, 1, 0, ET, "t1_c6_turn");
        step(0, 0, 1, 0, ET, "t1_c7_ldone_in_turn");
        step(0, 0, 0, 0, EI, "t1_c8_idle");
        step(0, 0, 0, 0, EI, "t1_c9_idle_hold");

        // both requests held: L, turn x2, idle, R, turn x2, idle, L
        do_reset("t2_reset");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, EL, "t2_own_l");
        step(1, 1, 1, 0, ET, "t2_turn_a1");
        step(1, 1, 0, 0, ET, "t2_turn_a2");
        step(1, 1, 0, 0, EI, "t2_idle_a");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, ER, "t2_own_r");
        step(1, 1, 0, 1, ET, "t2_turn_b1");
        step(1, 1, 0, 0, ET, "t2_turn_b2");
        step(1, 1, 0, 0, EI, "t2_idle_b");
        step(1, 1, 0, 0, EL, "t2_own_l_again");

        // done together with req drop is one release
        step(0, 0, 1, 0, ET, "t3_rel_t1");
        step(0, 0, 0, 0, ET, "t3_rel_t2");
        step(0, 0, 0, 0, EI, "t3_rel_idle");
        step(0, 1, 0, 0, ER, "t3_own_r");
        step(0, 1, 0, 0, ER, "t3_own_r_hold");

        // async reset mid-cycle while in OWN_R
        #3;
        rst = 1'b1;
        #1;
        expect_now(EI, "t3_async_rst_drop");
        @(posedge clk);
        #1;
        expect_now(EI, "t3_rst_held");
        rst = 1'b0;
        step(1, 1, 0, 0, EL, "t3_post_rst_tie_l");
        step(0, 0, 0, 0, ET, "t3_drop_turn");

`ifdef RNM_DIR_ARB_TIMEOUT_EN
        do_reset("t4_reset");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, EL, "t4_hold_l");
        step(1, 0, 0, 0, ETO, "t4_timeout");
        step(0, 0, 0, 0, ET, "t4_turn2");
        step(0, 0, 0, 0, EI, "t4_idle");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, EL, "t4b_hold_l");
        step(1, 0, 1, 0, ET, "t4b_done_no_timeout");
        step(0, 0, 0, 0, ET, "t4b_turn2");
        step(0, 0, 0, 0, EI, "t4b_idle");
`else
        do_reset("t4_reset");
        for (int i = 0; i < 1000; i++) step(1, 0, 0, 0, EL, "t4_unlimited_hold");
        step(0, 0, 0, 0, ET, "t4_release_turn");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
